// File: rtl/dest_pipe.sv
// Destination-register tracking pipeline (EX/MEM/WB slots) that feeds the hazard unit.
// Optional stall-cycle counter is enabled by defining DEST_PIPE_STALL_CNT_EN.
module dest_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic        id_regwrite,
  input  logic [4:0]  id_dest,
  output logic [4:0]  ex_dest,
  output logic [4:0]  mem_dest,
  output logic [4:0]  wb_dest,
  output logic        ex_regwrite,
  output logic        mem_regwrite,
  output logic        wb_regwrite,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic [1:0]  inflight,
  output logic [15:0] stall_cnt
);

  logic       ex_rw_q,   ex_rw_d;
  logic       mem_rw_q,  mem_rw_d;
  logic       wb_rw_q,   wb_rw_d;
  logic [4:0] ex_dest_q,  ex_dest_d;
  logic [4:0] mem_dest_q, mem_dest_d;
  logic [4:0] wb_dest_q,  wb_dest_d;
  logic       bubble;

  // Stall and flush collapse to a single bubble; flush also cancels the hold.
  assign bubble     = stall | flush;
  assign pc_hold    = stall & ~flush;
  assign if_id_hold = stall & ~flush;

  always_comb begin
    ex_rw_d    = 1'b0;
    ex_dest_d  = '0;
    mem_rw_d   = ex_rw_q;
    mem_dest_d = ex_dest_q;
    wb_rw_d    = mem_rw_q;
    wb_dest_d  = mem_dest_q;
    // $zero writes are dropped so they never look like a pending producer.
    if (!bubble && id_valid && id_regwrite && (id_dest != '0)) begin
      ex_rw_d   = 1'b1;
      ex_dest_d = id_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rw_q    <= 1'b0;
      ex_dest_q  <= '0;
      mem_rw_q   <= 1'b0;
      mem_dest_q <= '0;
      wb_rw_q    <= 1'b0;
      wb_dest_q  <= '0;
    end else begin
      ex_rw_q    <= ex_rw_d;
      ex_dest_q  <= ex_dest_d;
      mem_rw_q   <= mem_rw_d;
      mem_dest_q <= mem_dest_d;
      wb_rw_q    <= wb_rw_d;
      wb_dest_q  <= wb_dest_d;
    end
  end

  assign ex_regwrite  = ex_rw_q;
  assign mem_regwrite = mem_rw_q;
  assign wb_regwrite  = wb_rw_q;
  assign ex_dest      = ex_dest_q;
  assign mem_dest     = mem_dest_q;
  assign wb_dest      = wb_dest_q;
  assign inflight     = {1'b0, ex_rw_q} + {1'b0, mem_rw_q} + {1'b0, wb_rw_q};

`ifdef DEST_PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_q <= '0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dest_pipe.sv
// Directed bench for dest_pipe: a queue of expected slot contents is pushed on each
// driven cycle and popped as entries retire past WB.
module tb_dest_pipe;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid, id_regwrite;
  logic [4:0]  id_dest;
  logic [4:0]  ex_dest, mem_dest, wb_dest;
  logic        ex_regwrite, mem_regwrite, wb_regwrite;
  logic        pc_hold, if_id_hold;
  logic [1:0]  inflight;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic       rw;
    logic [4:0] dest;
  } slot_t;

  slot_t       exp_q[$];
  logic [15:0] exp_cnt;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  dest_pipe dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_regwrite(id_regwrite), .id_dest(id_dest),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .inflight(inflight), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check the combinational holds, then check all slots after the edge.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic v, input logic rw, input logic [4:0] d);
    slot_t nxt;
    slot_t gone;
    reset = r; stall = s; flush = f; id_valid = v; id_regwrite = rw; id_dest = d;
    #1;
    check("pc_hold", {15'd0, pc_hold}, {15'd0, s & ~f});
    check("if_id_hold", {15'd0, if_id_hold}, {15'd0, s & ~f});
    nxt.rw   = v & rw & (d != 5'd0) & ~s & ~f;
    nxt.dest = nxt.rw ? d : 5'd0;
    if (r) begin
      exp_q.delete();
      repeat (3) exp_q.push_back('0);
      exp_cnt = 16'd0;
    end else begin
      exp_q.push_back(nxt);
      gone = exp_q.pop_front();
`ifdef DEST_PIPE_STALL_CNT_EN
      if (s && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
    end
    @(posedge clk);
    #1;
    check("wb_regwrite",  {15'd0, wb_regwrite},  {15'd0, exp_q[0].rw});
    check("wb_dest",      {11'd0, wb_dest},      {11'd0, exp_q[0].dest});
    check("mem_regwrite", {15'd0, mem_regwrite}, {15'd0, exp_q[1].rw});
    check("mem_dest",     {11'd0, mem_dest},     {11'd0, exp_q[1].dest});
    check("ex_regwrite",  {15'd0, ex_regwrite},  {15'd0, exp_q[2].rw});
    check("ex_dest",      {11'd0, ex_dest},      {11'd0, exp_q[2].dest});
    check("inflight",     {14'd0, inflight},
          16'(exp_q[0].rw) + 16'(exp_q[1].rw) + 16'(exp_q[2].rw));
    check("stall_cnt",    stall_cnt, exp_cnt);
  endtask

  initial begin
    exp_cnt = 16'd0;
    repeat (3) exp_q.push_back('0);
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_regwrite = 1'b0; id_dest = 5'd0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset_inflight", {14'd0, inflight}, 16'd0);

    // Single instruction walks EX -> MEM -> WB.
    step(0, 0, 0, 1, 1, 5);
    check("d5_ex", {11'd0, ex_dest}, 16'd5);
    check("d5_inflight_ex", {14'd0, inflight}, 16'd1);
    step(0, 0, 0, 0, 0, 0);
    check("d5_mem", {11'd0, mem_dest}, 16'd5);
    check("d5_inflight_mem", {14'd0, inflight}, 16'd1);
    step(0, 0, 0, 0, 0, 0);
    check("d5_wb", {11'd0, wb_dest}, 16'd5);
    check("d5_inflight_wb", {14'd0, inflight}, 16'd1);
    step(0, 0, 0, 0, 0, 0);
    check("d5_left", {14'd0, inflight}, 16'd0);

    // Back-to-back fill.
    step(0, 0, 0, 1, 1, 8);
    step(0, 0, 0, 1, 1, 9);
    step(0, 0, 0, 1, 1, 10);
    check("full_wb8",  {11'd0, wb_dest},  16'd8);
    check("full_mem9", {11'd0, mem_dest}, 16'd9);
    check("full_ex10", {11'd0, ex_dest},  16'd10);
    check("full_inflight", {14'd0, inflight}, 16'd3);

    // Two stall cycles with dest 3 held in ID, then release.
    step(0, 1, 0, 1, 1, 3);
    check("stall1_ex_rw", {15'd0, ex_regwrite}, 16'd0);
    step(0, 1, 0, 1, 1, 3);
    check("stall2_ex_rw", {15'd0, ex_regwrite}, 16'd0);
    step(0, 0, 0, 1, 1, 3);
    check("stall_release_ex", {11'd0, ex_dest}, 16'd3);

    // $zero destination, flush alone, stall+flush together, invalid / non-writing.
    step(0, 0, 0, 1, 1, 0);
    check("zero_ex_rw", {15'd0, ex_regwrite}, 16'd0);
    check("zero_ex_dest", {11'd0, ex_dest}, 16'd0);
    step(0, 0, 1, 1, 1, 7);
    step(0, 1, 1, 1, 1, 7);
    check("sf_ex_rw", {15'd0, ex_regwrite}, 16'd0);
    step(0, 0, 0, 0, 1, 12);
    step(0, 0, 0, 1, 0, 13);
    step(0, 0, 0, 1, 1, 31);
    step(0, 0, 0, 1, 1, 1);

    // Reset with a full pipe, with stall asserted alongside it.
    step(0, 0, 0, 1, 1, 17);
    check("pre_reset_inflight", {14'd0, inflight}, 16'd3);
    step(1, 1, 0, 1, 1, 18);
    check("mid_reset_inflight", {14'd0, inflight}, 16'd0);
    check("mid_reset_wb_rw", {15'd0, wb_regwrite}, 16'd0);
    step(1, 0, 1, 1, 1, 19);
    step(0, 0, 0, 1, 1, 20);

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 200; i++)
      step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           1'($urandom), 1'($urandom), 5'($urandom));

`ifdef DEST_PIPE_STALL_CNT_EN
    for (int i = 0; i < 65540; i++)
      step(0, 1, 0, 0, 0, 0);
    check("cnt_saturated", stall_cnt, 16'hFFFF);
    step(0, 1, 0, 0, 0, 0);
    check("cnt_held", stall_cnt, 16'hFFFF);
    step(1, 0, 0, 0, 0, 0);
    check("cnt_reset", stall_cnt, 16'd0);
`else
    for (int i = 0; i < 20; i++)
      step(0, 1, 0, 0, 0, 0);
    check("cnt_tied_zero", stall_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dest_pipe.md
DEST_PIPE -- requirements
Module: dest_pipe

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with all state updating on the rising edge of clk.
REQ-002 clk  input  1  pipeline clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 stall  input  1  load-use/RAW stall from the hazard unit; 1 = hold IF/ID and PC, bubble ID/EX.
REQ-005 flush  input  1  taken branch/jump squash of the ID-stage instruction.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_regwrite  input  1  ID instruction writes the register file.
REQ-008 id_dest  input  5  ID instruction destination register (rd or rt, already selected).
REQ-009 ex_dest, mem_dest, wb_dest  output  5 each  destination register held in ID/EX, EX/MEM and MEM/WB.
REQ-010 ex_regwrite, mem_regwrite, wb_regwrite  output  1 each  qualified write-enable per stage.
REQ-011 pc_hold, if_id_hold  output  1 each  hold enables for the PC and the IF/ID register.
REQ-012 inflight  output  2  count of stages (EX, MEM, WB) with regwrite=1; range 0..3.
REQ-013 stall_cnt  output  16  saturating count of stalled cycles; see Configuration.

Function
REQ-014 The block SHALL form three slots (EX, MEM, WB), each holding {regwrite, dest}, that advance one stage per clock.
REQ-015 Each clock, MEM->WB and EX->MEM SHALL shift unconditionally; stall does not freeze downstream slots.
REQ-016 The EX slot SHALL load {id_valid & id_regwrite & (id_dest!=0), id_dest} when stall=0 and flush=0.
REQ-017 When stall=1 or flush=1, the EX slot SHALL load a bubble: regwrite=0, dest=0.
REQ-018 stall=1 and flush=1 in the same cycle SHALL produce exactly one bubble, treated identically to either input alone.
REQ-019 A destination of 0 SHALL never set regwrite, so $zero creates no false hazard.
REQ-020 A slot whose regwrite=0 SHALL drive dest=0.
REQ-021 pc_hold and if_id_hold SHALL equal stall combinationally, with zero latency, and SHALL be 0 whenever flush=1.
REQ-022 inflight SHALL equal the sum of ex_regwrite, mem_regwrite and wb_regwrite, derived combinationally from the registered slots.
REQ-023 An instruction accepted in cycle N SHALL appear on ex_* in N+1, mem_* in N+2 and wb_* in N+3, then leave.
REQ-024 The block SHALL sustain consecutive stall cycles indefinitely; every stalled cycle inserts one bubble while older entries drain.

Reset
REQ-025 While reset=1 at a clock edge, all slots SHALL clear to regwrite=0, dest=0, inflight SHALL read 0, and stall_cnt SHALL clear to 0.
REQ-026 Reset SHALL override stall and flush in the same cycle.
REQ-027 A reset asserted mid-operation SHALL discard all in-flight entries with no write-enable surviving it.
REQ-028 pc_hold and if_id_hold SHALL follow stall and flush even during reset.

Configuration
REQ-029 Macro DEST_PIPE_STALL_CNT_EN SHALL control the stall counter.
REQ-030 With DEST_PIPE_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 on each clock with stall=1 and reset=0, and SHALL saturate at 16'hFFFF.
REQ-031 Without DEST_PIPE_STALL_CNT_EN, the stall_cnt port SHALL remain present, be tied to 0, and have no counter register synthesized.

Verification
REQ-032 Reset, then issue id_valid=1, id_regwrite=1, id_dest=5 for one cycle -> ex_dest=5 at +1, mem_dest=5 at +2, wb_dest=5 at +3; inflight=1 in each of those cycles.
REQ-033 Issue dest=8, dest=9, dest=10 back-to-back -> inflight=3 at the cycle wb=8, mem=9, ex=10.
REQ-034 stall=1 for 2 cycles while id_dest=3 is held -> two bubbles enter EX, pc_hold=if_id_hold=1 during stall, and dest=3 enters EX only after stall drops.
REQ-035 Issue id_dest=0 with id_regwrite=1 -> ex_regwrite=0, ex_dest=0; also stall=1 with flush=1 -> one bubble, pc_hold=0.
REQ-036 Assert reset with 3 entries in flight -> all *_regwrite=0 and inflight=0 after the edge.
REQ-037 With DEST_PIPE_STALL_CNT_EN, preload the counter near 16'hFFFF and hold stall=1 -> stall_cnt stops at 16'hFFFF.
REQ-038 Without DEST_PIPE_STALL_CNT_EN, hold stall=1 -> stall_cnt stays 0.
